// File: rtl/countdown_timer_disp.sv
// countdown_timer_disp
//   MM:SS cooking-timer countdown with an 8-digit multiplexed 7-segment
//   display driver. Accepts start/stop/pause command pulses and a min/sec
//   preset, decrements once per TICK_DIV clocks, and raises done at 00:00.
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset
//   start    pulse: load (IDLE/DONE) or resume (PAUSED)
//   stop     pulse: abort to IDLE (highest priority)
//   pause    pulse: toggle RUN/PAUSED
//   min,sec  binary preset, saturated to 99 / 59
//   done     high while in DONE
//   an       digit anodes, active low (only an[3:0] used)
//   dec_cat  {dp,g,f,e,d,c,b,a}, active low
module countdown_timer_disp #(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    output logic       done,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [6:0]    cnt_min, cnt_min_nxt;
    logic [5:0]    cnt_sec, cnt_sec_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [6:0]    sat_min;
    logic [5:0]    sat_sec;
    logic          preset_nz;
    logic          tick;
    logic          last_tick;
    logic [6:0]    dec_min;
    logic [5:0]    dec_sec;

    // Tens/ones split by comparison against constant multiples of ten.
    function automatic logic [7:0] bcd2(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] o;
        t = '0;
        o = v;
        for (int unsigned i = 1; i <= 9; i++) begin
            if (v >= 7'(i * 10)) begin
                t = 4'(i);
                o = v - 7'(i * 10);
            end
        end
        return {t, o[3:0]};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_comb begin
        sat_min   = (min > 7'd99) ? 7'd99 : min;
        sat_sec   = (sec > 7'd59) ? 6'd59 : sec[5:0];
        preset_nz = (sat_min != '0) || (sat_sec != '0);
        tick      = (presc == PW'(TICK_DIV - 1));
        last_tick = (cnt_min == '0) && (cnt_sec == 6'd1);
        if (cnt_sec != '0) begin
            dec_min = cnt_min;
            dec_sec = cnt_sec - 6'd1;
        end else begin
            dec_min = cnt_min - 7'd1;
            dec_sec = 6'd59;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_min_nxt = cnt_min;
        cnt_sec_nxt = cnt_sec;
        presc_nxt   = presc;
        if (stop) begin
            state_nxt   = S_IDLE;
            presc_nxt   = '0;
            cnt_min_nxt = sat_min;
            cnt_sec_nxt = sat_sec;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_min_nxt = sat_min;
                    cnt_sec_nxt = sat_sec;
                    presc_nxt   = '0;
                    if (start && preset_nz) state_nxt = S_RUN;
                end
                S_RUN: begin
                    // The pause edge still advances the prescaler; the resume
                    // edge does not, so exactly TICK_DIV running edges per tick.
                    if (tick) begin
                        presc_nxt   = '0;
                        cnt_min_nxt = dec_min;
                        cnt_sec_nxt = dec_sec;
                        if (last_tick)  state_nxt = S_DONE;
                        else if (pause) state_nxt = S_PAUSED;
                    end else begin
                        presc_nxt = presc + 1'b1;
                        if (pause) state_nxt = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (start || pause) state_nxt = S_RUN;
                end
                S_DONE: begin
                    cnt_min_nxt = '0;
                    cnt_sec_nxt = '0;
                    if (start && preset_nz) begin
                        state_nxt   = S_RUN;
                        presc_nxt   = '0;
                        cnt_min_nxt = sat_min;
                        cnt_sec_nxt = sat_sec;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt_min <= '0;
            cnt_sec <= '0;
            presc   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_min <= cnt_min_nxt;
            cnt_sec <= cnt_sec_nxt;
            presc   <= presc_nxt;
            done    <= (state_nxt == S_DONE);
        end
    end

    // Display multiplexing
    logic [RW-1:0] rcnt;
    logic [1:0]    dig_sel;
    logic [7:0]    sec_bcd, min_bcd;
    logic [3:0]    digit;
    logic [7:0]    an_nxt, cat_nxt;

    always_comb begin
        sec_bcd = bcd2({1'b0, cnt_sec});
        min_bcd = bcd2(cnt_min);
        case (dig_sel)
            2'd0:    digit = sec_bcd[3:0];
            2'd1:    digit = sec_bcd[7:4];
            2'd2:    digit = min_bcd[3:0];
            default: digit = min_bcd[7:4];
        endcase
        an_nxt  = {4'hF, ~(4'b0001 << dig_sel)};
        cat_nxt = seg7(digit) & ((dig_sel == 2'd2) ? 8'h7F : 8'hFF);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt    <= '0;
            dig_sel <= '0;
            an      <= '1;
            dec_cat <= '1;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt    <= '0;
                dig_sel <= dig_sel + 2'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            an      <= an_nxt;
            dec_cat <= cat_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer_disp.sv
module tb_countdown_timer_disp;

    logic       clock;
    logic       reset;
    logic       start, stop, pause;
    logic [6:0] min, sec;
    logic       done;
    logic [7:0] an, dec_cat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [7:0] an_exp  [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [7:0] cat_exp [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};

    countdown_timer_disp #(.TICK_DIV(10), .REFRESH_DIV(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .min     (min),
        .sec     (sec),
        .done    (done),
        .an      (an),
        .dec_cat (dec_cat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cnt_now();
        return int'(dut.cnt_min) * 100 + int'(dut.cnt_sec);
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h required=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive command lines for exactly one rising edge.
    task automatic pulse(input logic s, input logic t, input logic p);
        start = s;
        stop  = t;
        pause = p;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
    endtask

    initial begin : stim
        logic       found;
        logic [7:0] prev;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        min   = 7'd0;
        sec   = 7'd3;
        wait_cyc(3);

        // Reset state
        push("rst_done", 0);     chk(done);
        push("rst_an", 8'hFF);   chk(an);
        push("rst_cat", 8'hFF);  chk(dec_cat);
        push("rst_cnt", 0);      chk(cnt_now());
        reset = 1'b1;
        push("first_an", 8'hFE);
        push("first_cat", 8'hC0);
        wait_cyc(1);
        chk(an);
        chk(dec_cat);
        push("idle_preview", 3);
        wait_cyc(1);
        chk(cnt_now());

        // Basic countdown 00:03
        pulse(1, 0, 0);
        push("t1_e9", 3);    wait_cyc(9);  chk(cnt_now());
        push("t1_e10", 2);   wait_cyc(1);  chk(cnt_now());
        push("t1_e20", 1);   wait_cyc(10); chk(cnt_now());
        push("t1_e29_done", 0); chk(done);
        push("t1_e30", 0);
        push("t1_e30_done", 1);
        wait_cyc(10);
        chk(cnt_now());
        chk(done);
        push("t1_done_hold", 1); wait_cyc(5); chk(done);
        pulse(0, 1, 0);
        push("t1_stop_done", 0); chk(done);
        push("t1_stop_idle", 3); wait_cyc(1); chk(cnt_now());

        // Borrow from 01:00
        min = 7'd1;
        sec = 7'd0;
        pulse(1, 0, 0);
        push("t2_e10", 59);  wait_cyc(10);  chk(cnt_now());
        push("t2_e20", 58);  wait_cyc(10);  chk(cnt_now());
        push("t2_e599", 1);
        push("t2_e599_done", 0);
        wait_cyc(579);
        chk(cnt_now());
        chk(done);
        push("t2_e600", 0);
        push("t2_e600_done", 1);
        wait_cyc(1);
        chk(cnt_now());
        chk(done);
        pulse(0, 1, 0);

        // Pause keeps partial prescaler
        min = 7'd0;
        sec = 7'd5;
        pulse(1, 0, 0);
        push("t3_e10", 4);     wait_cyc(10); chk(cnt_now());
        wait_cyc(3);
        pulse(0, 0, 1);
        push("t3_paused", 4);  chk(cnt_now());
        push("t3_e113", 4);    wait_cyc(99); chk(cnt_now());
        pulse(0, 0, 1);
        push("t3_e119", 4);    wait_cyc(5);  chk(cnt_now());
        push("t3_e120", 3);    wait_cyc(1);  chk(cnt_now());
        pulse(0, 1, 0);

        // Saturation and ignored commands
        min = 7'd120;
        sec = 7'd75;
        push("t4_sat", 9959);  wait_cyc(1); chk(cnt_now());
        min = 7'd0;
        sec = 7'd0;
        pulse(1, 0, 0);
        wait_cyc(15);
        push("t4_zero_done", 0);  chk(done);
        push("t4_zero_cnt", 0);   chk(cnt_now());
        sec = 7'd7;
        push("t4_zero_idle", 7);  wait_cyc(1); chk(cnt_now());
        pulse(1, 1, 0);
        wait_cyc(15);
        push("t4_stopstart_cnt", 7);  chk(cnt_now());
        push("t4_stopstart_done", 0); chk(done);

        // Display scan of 12:34
        min = 7'd12;
        sec = 7'd34;
        wait_cyc(2);
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
            else prev = an;
        end
        push("t5_sync", 1); chk(found);
        if (found) begin
            for (int s = 0; s < 16; s++) begin
                if (s != 0) @(negedge clock);
                push($sformatf("t5_an_%0d", s), an_exp[s/4]);
                chk(an);
                push($sformatf("t5_cat_%0d", s), cat_exp[s/4]);
                chk(dec_cat);
            end
        end

        // Async reset mid-RUN
        min = 7'd0;
        sec = 7'd9;
        pulse(1, 0, 0);
        push("t6_e20", 7); wait_cyc(20); chk(cnt_now());
        #2 reset = 1'b0;
        #1;
        push("t6_rst_done", 0);    chk(done);
        push("t6_rst_an", 8'hFF);  chk(an);
        push("t6_rst_cat", 8'hFF); chk(dec_cat);
        push("t6_rst_cnt", 0);     chk(cnt_now());
        @(negedge clock);
        reset = 1'b1;
        push("t6_idle", 9);        wait_cyc(2);  chk(cnt_now());
        push("t6_no_resume", 9);   wait_cyc(30); chk(cnt_now());
        push("t6_no_done", 0);     chk(done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
